uart_rx_fsm: RTL

Receive controller for the UART RX path. Detects the start bit, drives the enable of the sibling edge/bit counter, and majority-votes three oversamples per bit from the counter's position outputs. It deserializes 8 data bits LSB-first, checks optional parity and the stop bit, and presents the byte with a one-cycle valid strobe.

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_data_sampling.sv | 29 ++
 rtl/uart_rx_fsm.sv | 72 +++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared states, frame constants and sample-point helper for the UART receiver.
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD = 1'b1;
  localparam int DATA_WIDTH = 8;
  localparam int SAMPLE_OFS0 = -2;
  localparam int SAMPLE_OFS1 = -1;
  localparam int SAMPLE_OFS2 = 0;
  localparam int DP_OFS = 1;
  function automatic logic [2:0] edge_at(input logic [3:0] prescale, input int ofs);
    return 3'(int'(prescale >> 1) + ofs);
  endfunction
endpackage

// File: rtl/uart_rx_data_sampling.sv
// uart_rx_data_sampling: three oversamples around mid-bit, majority registered on the last tap.
module uart_rx_data_sampling
  import uart_rx_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RX_IN,
  input  logic [3:0] Prescale,
  input  logic [2:0] Edge_count,
  input  logic       Enable,
  output logic       sampled_bit
);
  logic [1:0] r_taps;
  logic       w_s0, w_s1, w_s2;
  assign w_s0 = Enable && (Edge_count == edge_at(Prescale, SAMPLE_OFS0));
  assign w_s1 = Enable && (Edge_count == edge_at(Prescale, SAMPLE_OFS1));
  assign w_s2 = Enable && (Edge_count == edge_at(Prescale, SAMPLE_OFS2));
  // third tap votes straight from the line so the result is ready at the decision point
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_taps      <= '0;
      sampled_bit <= 1'b0;
    end else begin
      if (w_s0) r_taps[0] <= RX_IN;
      if (w_s1) r_taps[1] <= RX_IN;
      if (w_s2) sampled_bit <= (r_taps[0] & r_taps[1]) | (r_taps[0] & RX_IN) | (r_taps[1] & RX_IN);
    end
  end
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive controller; frames start/data/parity/stop and checks the byte.
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  RX_IN,
  input  logic [3:0]            Prescale,
  input  logic                  Parity_EN,
  input  logic                  Parity_TYP,
  input  logic [2:0]            Edge_count,
  input  logic [3:0]            Bit_count,
  output logic                  Enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  w_sampled, w_dp, w_eb;
  assign Enable = (r_state != IDLE);
  assign w_dp   = (Edge_count == edge_at(Prescale, DP_OFS));
  assign w_eb   = (Edge_count == 3'(Prescale - 4'd1));
  uart_rx_data_sampling u_sampling (
    .Clk        (Clk),
    .Rst        (Rst),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .Edge_count (Edge_count),
    .Enable     (Enable),
    .sampled_bit(w_sampled)
  );
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = RX_IN ? IDLE : START;
      START:   w_next = !w_eb ? START : (w_sampled ? IDLE : DATA);
      DATA:    w_next = (w_eb && Bit_count == 4'd8) ? (Parity_EN ? PARITY : STOP) : DATA;
      PARITY:  w_next = w_eb ? STOP : PARITY;
      STOP:    w_next = w_eb ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  // with Prescale=4 the decision point coincides with end of bit, so the stop check reads the vote directly
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_shift      <= '0;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      if (r_state == IDLE && !RX_IN) begin
        Parity_Error <= 1'b0;
        Stop_Error   <= 1'b0;
      end
      if (r_state == DATA && w_dp) r_shift <= {w_sampled, r_shift[DATA_WIDTH-1:1]};
      if (r_state == PARITY && w_dp) Parity_Error <= w_sampled ^ (^r_shift) ^ (Parity_TYP == PARITY_ODD);
      if (r_state == STOP && w_dp) Stop_Error <= ~w_sampled;
      if (r_state == STOP && w_eb && w_sampled && !Parity_Error) begin
        P_DATA     <= r_shift;
        Data_Valid <= 1'b1;
      end
    end
  end
endmodule
